// File: rtl/out_ser_cell.sv
// Fabric-to-pad output serializer: accepts a WIDTH-bit word on valid/ready and shifts it to OQZ one bit per IQC cycle.
// Optional pad bypass via OSEL when OUT_SER_CELL_OSEL_BYPASS_EN is defined.
module out_ser_cell #(
  parameter int   WIDTH      = 4,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic [WIDTH-1:0] F2A_DATA,
  input  logic             F2A_VALID,
  input  logic             F2A_OE,
`ifdef OUT_SER_CELL_OSEL_BYPASS_EN
  input  logic             OSEL,
`endif
  output logic             F2A_READY,
  output logic             OQZ,
  output logic             OEZ,
  output logic             BUSY
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             oqz_q, oqz_d;
  logic             oez_q, oez_d;
  logic             busy_q, busy_d;
  logic             bypass;
  logic             accept;

`ifdef OUT_SER_CELL_OSEL_BYPASS_EN
  assign bypass = OSEL;
`else
  assign bypass = 1'b0;
`endif

  // Ready in the last bit slot lets the next word follow with no idle gap.
  assign F2A_READY = !QRT && !bypass &&
                     ((state_q == S_IDLE) || ((state_q == S_SHIFT) && (cnt_q == LAST)));
  assign accept    = F2A_VALID && F2A_READY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    oqz_d   = oqz_q;
    oez_d   = oez_q;
    busy_d  = busy_q;
    if (bypass || (!accept && (state_q == S_SHIFT) && (cnt_q == LAST))) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      oqz_d   = IDLE_LEVEL;
      oez_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (accept) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      oez_d   = F2A_OE;
      busy_d  = 1'b1;
      if (MSB_FIRST) begin
        oqz_d = F2A_DATA[WIDTH-1];
        sr_d  = F2A_DATA << 1;
      end else begin
        oqz_d = F2A_DATA[0];
        sr_d  = F2A_DATA >> 1;
      end
    end else if (state_q == S_SHIFT) begin
      cnt_d = cnt_q + 1'b1;
      if (MSB_FIRST) begin
        oqz_d = sr_q[WIDTH-1];
        sr_d  = sr_q << 1;
      end else begin
        oqz_d = sr_q[0];
        sr_d  = sr_q >> 1;
      end
    end
  end

  always_ff @(posedge IQC) begin
    if (QRT) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      oqz_q   <= IDLE_LEVEL;
      oez_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      oqz_q   <= oqz_d;
      oez_q   <= oez_d;
      busy_q  <= busy_d;
    end
  end

`ifdef OUT_SER_CELL_OSEL_BYPASS_EN
  assign OQZ = bypass ? F2A_DATA[0] : oqz_q;
  assign OEZ = bypass ? F2A_OE : oez_q;
`else
  assign OQZ = oqz_q;
  assign OEZ = oez_q;
`endif
  assign BUSY = busy_q;

endmodule
